// File: rtl/data_memory_arbiter_if.sv
// Bundle of the core, restore, debug, ROM and data-memory signals seen by the
// data memory arbiter. slave is the arbiter's view, master the surrounding system.
interface data_memory_arbiter_if #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32
);
   logic              core_req;
   logic [ADDR_W-1:0] core_addr;
   logic [DATA_W-1:0] core_wdata;
   logic              core_wren;
   logic              core_stall;
   logic              restore_req;
   logic              restore_busy;
   logic              restore_done;
   logic              dbg_req;
   logic [ADDR_W-1:0] dbg_addr;
   logic              dbg_ack;
   logic [DATA_W-1:0] dbg_rdata;
   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_data;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_wren;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  core_req, core_addr, core_wdata, core_wren,
      input  restore_req, dbg_req, dbg_addr, rom_data, mem_rdata,
      output core_stall, restore_busy, restore_done, dbg_ack, dbg_rdata,
      output rom_addr, mem_addr, mem_wdata, mem_wren
   );

   modport master (
      output core_req, core_addr, core_wdata, core_wren,
      output restore_req, dbg_req, dbg_addr, rom_data, mem_rdata,
      input  core_stall, restore_busy, restore_done, dbg_ack, dbg_rdata,
      input  rom_addr, mem_addr, mem_wdata, mem_wren
   );
endinterface

// File: rtl/data_memory_arbiter.sv
// Shares the single data-memory port between the core (zero-latency when idle),
// the reset-image restore sequencer and a starvation-protected debug read port.
module data_memory_arbiter #(
   parameter int ADDR_W       = 6,
   parameter int DATA_W       = 32,
   parameter int DEPTH        = 64,
   parameter int STARVE_LIMIT = 4
) (
   input logic                  clock,
   input logic                  reset,
   data_memory_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RESTORE_RD, RESTORE_WR, DBG_RD} state_t;

   localparam logic [2:0]        STARVE_MAX = 3'(STARVE_LIMIT - 1);
   localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(DEPTH - 1);

   state_t            state_reg, state_next;
   logic [ADDR_W-1:0] idx_reg, idx_next;
   logic [2:0]        starve_reg, starve_next;
   logic              dbg_pend_reg;
   logic              dbg_ack_reg;
   logic              restore_done_reg;
   logic [DATA_W-1:0] dbg_rdata_reg;
   logic              dbg_live;
   logic              dbg_grant;
   logic              last_word;

   // A request already granted stays high until its ack is seen; it must not
   // be granted again nor age the starvation counter in the meantime.
   assign dbg_live  = bus.dbg_req & ~dbg_pend_reg & ~dbg_ack_reg;
   assign last_word = (idx_reg == LAST_IDX);

   always_comb begin
      state_next    = state_reg;
      idx_next      = idx_reg;
      starve_next   = starve_reg;
      dbg_grant     = 1'b0;
      bus.mem_addr  = idx_reg;
      bus.mem_wdata = '0;
      bus.mem_wren  = 1'b0;
      case (state_reg)
         IDLE: begin
            bus.mem_addr  = bus.core_addr;
            bus.mem_wdata = bus.core_wdata;
            bus.mem_wren  = bus.core_req & bus.core_wren;
            dbg_grant     = ~bus.restore_req & dbg_live
                            & (~bus.core_req | (starve_reg == STARVE_MAX));
            if (bus.restore_req) begin
               state_next = RESTORE_RD;
               idx_next   = '0;
            end else if (dbg_grant) begin
               state_next = DBG_RD;
            end
            // Saturating keeps the preemption compare valid if restores delay the grant.
            if (!dbg_live || dbg_grant) begin
               starve_next = '0;
            end else if (bus.core_req && (starve_reg != STARVE_MAX)) begin
               starve_next = starve_reg + 3'd1;
            end
         end
         RESTORE_RD: begin
            state_next = RESTORE_WR;
         end
         RESTORE_WR: begin
            bus.mem_wdata = bus.rom_data;
            bus.mem_wren  = 1'b1;
            if (last_word) begin
               idx_next   = '0;
               state_next = IDLE;
            end else begin
               idx_next = idx_reg + 1'b1;
               state_next = RESTORE_RD;
            end
         end
         DBG_RD: begin
            bus.mem_addr = bus.dbg_addr;
            state_next   = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg        <= IDLE;
         idx_reg          <= '0;
         starve_reg       <= '0;
         dbg_pend_reg     <= 1'b0;
         dbg_ack_reg      <= 1'b0;
         dbg_rdata_reg    <= '0;
         restore_done_reg <= 1'b0;
      end else begin
         state_reg        <= state_next;
         idx_reg          <= idx_next;
         starve_reg       <= starve_next;
         // Capture needs no port, so it completes even if a restore starts meanwhile.
         dbg_pend_reg     <= (state_reg == DBG_RD);
         dbg_ack_reg      <= dbg_pend_reg;
         if (dbg_pend_reg) begin
            dbg_rdata_reg <= bus.mem_rdata;
         end
         restore_done_reg <= (state_reg == RESTORE_WR) && last_word;
      end
   end

   assign bus.core_stall   = (state_reg != IDLE);
   assign bus.restore_busy = (state_reg == RESTORE_RD) || (state_reg == RESTORE_WR);
   assign bus.restore_done = restore_done_reg;
   assign bus.dbg_ack      = dbg_ack_reg;
   assign bus.dbg_rdata    = dbg_rdata_reg;
   assign bus.rom_addr     = idx_reg;
endmodule
